// File: rtl/vdma_burst_arbiter_pkg.sv
// Shared types and helpers for the VDMA burst-command arbiter.
// Holds the arbiter state encoding and the modulo-NUM index arithmetic.
package SystemPkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      BUSY   = 2'd2,
      FINISH = 2'd3
   } arb_state_t;

   localparam int ARB_MAX_NUM = 8;
   localparam int ARB_IDX_W   = $clog2(ARB_MAX_NUM) + 1;

   typedef logic [ARB_IDX_W-1:0] arb_idx_t;

   // (base + off) mod num, valid while base and off are both below num
   function automatic arb_idx_t wrap_add(input arb_idx_t base,
                                         input arb_idx_t off,
                                         input arb_idx_t num);
      arb_idx_t sum;
      sum = base + off;
      if (sum >= num) begin
         sum = sum - num;
      end
      return sum;
   endfunction

endpackage

// File: rtl/vdma_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM.
module vdma_rr_pick
   import SystemPkg::*;
#(
   parameter  int NUM = 4,
   localparam int IDW = $clog2(NUM)
) (
   input  logic [NUM-1:0] req,
   input  logic [IDW-1:0] ptr,
   output logic           any,
   output logic [IDW-1:0] winner
);

   logic [2*NUM-1:0] req_dbl;
   logic [NUM-1:0]   req_rot;
   arb_idx_t         offset;

   // Rotate so that bit 0 is the requester ptr points at
   assign req_dbl = {req, req};
   assign req_rot = NUM'(req_dbl >> ptr);

   // NOTE: offset gets its default before the loop so no path leaves it
   // unassigned and infers a latch.
   always_comb begin
      offset = '0;
      for (int j = NUM - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            offset = arb_idx_t'(j);
         end
      end
   end

   assign any    = |req;
   assign winner = IDW'(wrap_add(arb_idx_t'(ptr), offset, arb_idx_t'(NUM)));

endmodule

// File: rtl/vdma_burst_arbiter.sv
// Round-robin arbiter sharing one AXI burst-command port between NUM
// FIFO-status controllers, with one command outstanding at a time.
module vdma_burst_arbiter
   import SystemPkg::*;
#(
   parameter int NUM   = 4,
   parameter int LSIZE = 9,
   parameter int IDW   = $clog2(NUM)
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [NUM-1:0]     burst_req,
   input  logic [NUM-1:0]     tail_req,
   input  logic [NUM*LSIZE-1:0] req_len,
   output logic [NUM-1:0]     resp,
   output logic [NUM-1:0]     done,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   output logic [LSIZE-1:0]   cmd_len,
   output logic               cmd_tail,
   output logic [IDW-1:0]     cmd_id,
   input  logic               xfer_done,
   output logic               busy
);

   arb_state_t       state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [LSIZE-1:0] cmd_len_q, cmd_len_d;
   logic             cmd_tail_q, cmd_tail_d;
   logic [IDW-1:0]   cmd_id_q, cmd_id_d;
   logic [NUM-1:0]   resp_q, resp_d;
   logic [NUM-1:0]   done_q, done_d;
   logic             busy_q, busy_d;

   logic [NUM-1:0]   req_any;
   logic             pick_any;
   logic [IDW-1:0]   pick_winner;
   logic [LSIZE-1:0] sel_len;
   logic             sel_tail;
   logic [NUM-1:0]   id_onehot;

   assign req_any = burst_req | tail_req;

   vdma_rr_pick #(
      .NUM (NUM)
   ) u_pick (
      .req    (req_any),
      .ptr    (ptr_q),
      .any    (pick_any),
      .winner (pick_winner)
   );

   always_comb begin
      sel_len  = '0;
      sel_tail = 1'b0;
      for (int i = 0; i < NUM; i++) begin
         if (pick_winner == IDW'(i)) begin
            sel_len  = req_len[i*LSIZE +: LSIZE];
            sel_tail = tail_req[i];
         end
      end
   end

   assign id_onehot = {{(NUM-1){1'b0}}, 1'b1} << cmd_id_q;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cmd_valid_d = cmd_valid_q;
      cmd_len_d   = cmd_len_q;
      cmd_tail_d  = cmd_tail_q;
      cmd_id_d    = cmd_id_q;
      resp_d      = '0;
      done_d      = '0;

      case (state_q)
         IDLE: begin
            if (enable && pick_any) begin
               state_d     = ISSUE;
               cmd_valid_d = 1'b1;
               cmd_id_d    = pick_winner;
               cmd_len_d   = sel_len;
               cmd_tail_d  = sel_tail;
               ptr_d       = IDW'(wrap_add(arb_idx_t'(pick_winner), arb_idx_t'(1),
                                           arb_idx_t'(NUM)));
            end
         end
         ISSUE: begin
            // The command is owed to the AXI master even if the request drops
            if (cmd_ready) begin
               state_d     = BUSY;
               cmd_valid_d = 1'b0;
               resp_d      = id_onehot;
            end
         end
         BUSY: begin
            if (xfer_done) begin
               state_d = FINISH;
               done_d  = id_onehot;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: non-blocking assignments here so every flop samples the
   // pre-edge value of the others, independent of statement order.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_len_q   <= '0;
         cmd_tail_q  <= 1'b0;
         cmd_id_q    <= '0;
         resp_q      <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_len_q   <= cmd_len_d;
         cmd_tail_q  <= cmd_tail_d;
         cmd_id_q    <= cmd_id_d;
         resp_q      <= resp_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_len   = cmd_len_q;
   assign cmd_tail  = cmd_tail_q;
   assign cmd_id    = cmd_id_q;
   assign resp      = resp_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_vdma_burst_arbiter.sv
// Self-checking bench for vdma_burst_arbiter: directed scenarios plus a
// randomized transaction loop against a transaction-level round-robin model.
module tb_vdma_burst_arbiter;

   localparam int NUM   = 4;
   localparam int LSIZE = 9;
   localparam int IDW   = 2;

   logic                 clock = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 enable = 1'b0;
   logic [NUM-1:0]       burst_req = '0;
   logic [NUM-1:0]       tail_req = '0;
   logic [NUM*LSIZE-1:0] req_len = '0;
   logic                 cmd_ready = 1'b0;
   logic                 xfer_done = 1'b0;
   logic [NUM-1:0]       resp;
   logic [NUM-1:0]       done;
   logic                 cmd_valid;
   logic [LSIZE-1:0]     cmd_len;
   logic                 cmd_tail;
   logic [IDW-1:0]       cmd_id;
   logic                 busy;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ptr  = 0;

   vdma_burst_arbiter #(
      .NUM   (NUM),
      .LSIZE (LSIZE),
      .IDW   (IDW)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .enable    (enable),
      .burst_req (burst_req),
      .tail_req  (tail_req),
      .req_len   (req_len),
      .resp      (resp),
      .done      (done),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .cmd_tail  (cmd_tail),
      .cmd_id    (cmd_id),
      .xfer_done (xfer_done),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Round-robin rule: first requester at or after the pointer, modulo NUM
   function automatic int model_pick();
      for (int k = 0; k < NUM; k++) begin
         int i;
         i = (exp_ptr + k) % NUM;
         if (burst_req[i] || tail_req[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [LSIZE-1:0] len_of(input int i);
      return req_len[i*LSIZE +: LSIZE];
   endfunction

   task automatic set_len(input int i, input int v);
      req_len[i*LSIZE +: LSIZE] = LSIZE'(v);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, cmd_valid, 0);
      check({tag, "_resp"}, resp, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic gate(input int n);
      enable = 1'b0;
      for (int c = 0; c < n; c++) begin
         cmd_ready = 1'($urandom_range(0, 1));
         xfer_done = 1'($urandom_range(0, 1));
         @(negedge clock);
         check_idle("gate");
      end
      cmd_ready = 1'b0;
      xfer_done = 1'b0;
   endtask

   task automatic add_random_reqs();
      for (int i = 0; i < NUM; i++) begin
         if (!(burst_req[i] || tail_req[i]) && $urandom_range(0, 1) == 1) begin
            set_len(i, $urandom_range(1, (1 << LSIZE) - 1));
            if ($urandom_range(0, 3) == 0) tail_req[i] = 1'b1;
            else burst_req[i] = 1'b1;
         end
      end
      if ((burst_req | tail_req) == '0) begin
         int k;
         k = $urandom_range(0, NUM - 1);
         burst_req[k] = 1'b1;
         set_len(k, $urandom_range(0, (1 << LSIZE) - 1));
      end
   endtask

   // Called at a falling edge while the DUT is idle with requests applied
   task automatic run_txn(input int bp, input int busy_cyc, input bit withdraw,
                          input bit keep, input int new_len, input bit drop_en,
                          output int gid);
      int               w;
      logic [LSIZE-1:0] e_len;
      logic             e_tail;
      logic [NUM-1:0]   oh;

      enable = 1'b1;
      w = model_pick();
      gid = w;
      if (w < 0) return;
      e_len  = len_of(w);
      e_tail = tail_req[w];
      oh     = NUM'(1) << w;
      exp_ptr = (w + 1) % NUM;

      @(negedge clock);
      check("grant_valid", cmd_valid, 1);
      check("grant_id", cmd_id, w);
      check("grant_len", cmd_len, e_len);
      check("grant_tail", cmd_tail, e_tail);
      check("grant_busy", busy, 1);
      check("grant_resp", resp, 0);
      check("grant_done", done, 0);

      if (drop_en) enable = 1'b0;
      if (new_len >= 0) set_len(w, new_len);
      if (withdraw) begin
         burst_req[w] = 1'b0;
         tail_req[w]  = 1'b0;
      end

      for (int c = 0; c < bp; c++) begin
         cmd_ready = 1'b0;
         xfer_done = 1'($urandom_range(0, 1));
         if (!drop_en) enable = 1'($urandom_range(0, 1));
         @(negedge clock);
         check("bp_valid", cmd_valid, 1);
         check("bp_id", cmd_id, w);
         check("bp_len", cmd_len, e_len);
         check("bp_tail", cmd_tail, e_tail);
         check("bp_resp", resp, 0);
      end

      cmd_ready = 1'b1;
      xfer_done = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("hs_valid", cmd_valid, 0);
      check("hs_resp", resp, oh);
      check("hs_done", done, 0);
      check("hs_busy", busy, 1);

      if (!keep) begin
         burst_req[w] = 1'b0;
         tail_req[w]  = 1'b0;
      end
      xfer_done = 1'b0;

      for (int c = 0; c < busy_cyc; c++) begin
         cmd_ready = 1'($urandom_range(0, 1));
         if (!drop_en) enable = 1'($urandom_range(0, 1));
         @(negedge clock);
         check("busy_resp", resp, 0);
         check("busy_done", done, 0);
         check("busy_busy", busy, 1);
         check("busy_valid", cmd_valid, 0);
      end

      xfer_done = 1'b1;
      cmd_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("fin_done", done, oh);
      check("fin_resp", resp, 0);
      check("fin_busy", busy, 1);
      check("fin_valid", cmd_valid, 0);

      xfer_done = 1'b0;
      cmd_ready = 1'b0;
      @(negedge clock);
      check_idle("post");
      enable = 1'b1;
   endtask

   initial begin
      int gid;
      int prev;

      rst_n = 1'b0;
      repeat (3) @(negedge clock);
      check_idle("reset");
      check("reset_len", cmd_len, 0);
      check("reset_id", cmd_id, 0);
      check("reset_tail", cmd_tail, 0);

      // Single full-burst request, master always ready
      rst_n = 1'b1;
      burst_req[2] = 1'b1;
      set_len(2, 100);
      run_txn(0, 2, 1'b0, 1'b0, -1, 1'b0, gid);
      check("single_id", gid, 2);

      // Tail command with a length change while the command is pending
      tail_req[1] = 1'b1;
      set_len(1, 37);
      run_txn(2, 1, 1'b0, 1'b0, 5, 1'b0, gid);

      // Ten cycles of backpressure with the request withdrawn
      burst_req[0] = 1'b1;
      set_len(0, 200);
      run_txn(10, 3, 1'b1, 1'b0, -1, 1'b0, gid);

      // Enable gating in idle, then enable dropped for the whole command
      burst_req[3] = 1'b1;
      set_len(3, 12);
      tail_req[2] = 1'b1;
      set_len(2, 7);
      gate(5);
      run_txn(1, 3, 1'b0, 1'b0, -1, 1'b1, gid);
      check("gate_id", gid, 2);

      // Reset while a command is in flight
      burst_req = '0;
      tail_req  = '0;
      burst_req[1] = 1'b1;
      set_len(1, 10);
      enable = 1'b1;
      @(negedge clock);
      check("rst_pre_id", cmd_id, 1);
      cmd_ready = 1'b1;
      @(negedge clock);
      check("rst_pre_resp", resp, 4'b0010);
      burst_req[1] = 1'b0;
      cmd_ready = 1'b0;
      @(negedge clock);
      check("rst_pre_busy", busy, 1);
      rst_n = 1'b0;
      xfer_done = 1'b1;
      @(negedge clock);
      check_idle("rst_mid");
      check("rst_mid_len", cmd_len, 0);
      check("rst_mid_id", cmd_id, 0);
      check("rst_mid_tail", cmd_tail, 0);
      rst_n = 1'b1;
      xfer_done = 1'b0;
      exp_ptr = 0;

      // Every requester permanently requesting
      for (int i = 0; i < NUM; i++) begin
         burst_req[i] = 1'b1;
         set_len(i, 50 + i);
      end
      prev = -1;
      for (int k = 0; k < 2 * NUM; k++) begin
         run_txn($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b1, -1, 1'b0, gid);
         check("rr_order", gid, k % NUM);
         check("rr_no_repeat", (gid == prev) ? 1 : 0, 0);
         prev = gid;
      end

      // Randomized traffic
      burst_req = '0;
      tail_req  = '0;
      for (int t = 0; t < 60; t++) begin
         add_random_reqs();
         if ($urandom_range(0, 4) == 0) gate($urandom_range(1, 3));
         run_txn($urandom_range(0, 4), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0),
                 1'b0,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 511)) : -1,
                 ($urandom_range(0, 3) == 0),
                 gid);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vdma_burst_arbiter.md
# vdma_burst_arbiter

Shares one AXI burst-command port between `NUM` FIFO-status controllers: read-side and write-side controllers for each VDMA channel. Each controller raises `burst_req` or `tail_req` with a `req_len`. The arbiter grants one requester at a time in round-robin order and forwards its command to the AXI master. It returns the one-cycle `resp` / `done` pulses the controllers' state machines wait on. Only one command is outstanding at a time.

## Interface
- `NUM`, 4: number of requesters (2..8)
- `LSIZE`, 9: burst-length width, equal to the controllers' `LSIZE`
- `IDW`, `$clog2(NUM)`: width of the requester index
- `clock` in 1: single clock for the whole block
- `rst_n` in 1: reset, synchronous and active-low
- `enable` in 1: 0 blocks new grants; an in-flight command still completes
- `burst_req` in NUM: per-requester full-burst request, level-held until `resp`
- `tail_req` in NUM: per-requester tail request, level-held until `resp`; never high together with the same requester's `burst_req`
- `req_len` in NUM*LSIZE: packed lengths; requester i uses bits [i*LSIZE +: LSIZE]
- `resp` out NUM: one-cycle pulse to the granted requester when its command is accepted
- `done` out NUM: one-cycle pulse to the granted requester when its transfer completes
- `cmd_valid` out 1: command valid toward the AXI master
- `cmd_ready` in 1: AXI master accepts the command
- `cmd_len` out LSIZE: granted length
- `cmd_tail` out 1: 1 = tail command
- `cmd_id` out IDW: granted requester index
- `xfer_done` in 1: AXI master pulse, last beat of the accepted command finished
- `busy` out 1: high in every state except IDLE

## Operation
- State machine, one-hot or encoded:
  - **IDLE**: if `enable` and any `burst_req|tail_req` is high, pick the winner, latch its id, length and tail flag, go to ISSUE.
  - **ISSUE**: `cmd_valid`=1. On `cmd_ready`, go to BUSY and pulse `resp[id]`.
  - **BUSY**: on `xfer_done`, go to FINISH and pulse `done[id]`.
  - **FINISH**: one cycle, then IDLE. This cycle gives the requester time to drop its stale request level.
- **Round-robin:** search starts at `ptr`, wrapping modulo NUM. `ptr` ← winner+1 (wrap to 0 past NUM-1). `ptr` updates on the IDLE→ISSUE transition only.
- **Length latch:** `cmd_len` = `req_len` slice of the winner, sampled at grant. `cmd_tail` = `tail_req[winner]`. Later changes on `req_len` are ignored.
- **Request withdrawn during ISSUE** (requester resynced on `fsync`): `cmd_valid` stays high until `cmd_ready`; the command completes normally and `resp`/`done` still pulse. Requesters ignore these pulses in their reset state.
- **`enable`=0:**
  - In IDLE: hold IDLE.
  - In other states: no effect.
- **Out-of-order pulses:**
  - `xfer_done` in IDLE or ISSUE: ignored.
  - `cmd_ready` outside ISSUE: ignored.
- **Reset mid-operation:** all state returns to reset values on the next edge. No pulse is emitted.
- **Reset values:**
  - state IDLE, `ptr` 0
  - `cmd_valid` 0, `cmd_len` 0, `cmd_tail` 0, `cmd_id` 0
  - `resp` 0, `done` 0, `busy` 0

## Timing
- All outputs are registered.
- **Request to command:** request high in IDLE at edge t gives `cmd_valid`, `cmd_len`, `cmd_id` high/valid from t+1.
- **`resp`:** handshake at edge t (`cmd_valid`&`cmd_ready`) gives `cmd_valid`=0 and `resp[id]`=1 during t+1 only.
- **`done`:** `xfer_done` at edge t gives `done[id]`=1 during t+1 only, in FINISH. State is IDLE at t+2; the earliest next `cmd_valid` is t+3.
- **Same-cycle `cmd_ready` on ISSUE entry:** accepted. The minimum ISSUE dwell is 1 cycle.
- **Worst-case wait:** a pending requester is granted within NUM-1 other commands.

## Structure
- In `SystemPkg`:
  - `arb_state_t` enum: IDLE, ISSUE, BUSY, FINISH
  - `ARB_MAX_NUM` = 8 constant
- Sub-module `vdma_rr_pick` (combinational):
  - Parameter: NUM.
  - Inputs: `req`[NUM], `ptr`[IDW].
  - Outputs: `any`, `winner`[IDW].
  - Unit-testable on its own.

## Test plan
- **Single request:** NUM=4, `burst_req`[2]=1, `req_len`[2]=100, `cmd_ready` tied 1.
  - `cmd_valid` one cycle later with `cmd_len`=100, `cmd_id`=2, `cmd_tail`=0.
  - `resp`[2] pulses once.
  - `xfer_done` gives one `done`[2] pulse; then IDLE.
- **All requesters permanently requesting:** grant order 0,1,2,3,0,…; no requester granted twice in a row.
- **Tail command:** `tail_req`[1]=1, len 37 gives `cmd_tail`=1, `cmd_len`=37; `req_len` changed to 5 during ISSUE leaves `cmd_len`=37.
- **Backpressure:** `cmd_ready` low 10 cycles.
  - `cmd_valid` and the command fields stay stable throughout.
  - `resp` only on the cycle after the handshake.
  - A withdrawn request still completes.
- **Enable gating:** `enable`=0 with requests pending gives no `cmd_valid`. `enable` dropped while BUSY still delivers `done`.
- **Reset in BUSY:** `rst_n` low 1 cycle gives all outputs 0 and `ptr`=0 at the next edge, and no `done` pulse.
